// File: rtl/ram_bus_bridge_pkg.sv
// Shared definitions for the CPU-bus to block-RAM bridge: state encoding,
// default error read data and the RAM window decode.
package ram_bus_bridge_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned CPU_W     = 32;
    localparam int unsigned STRB_W    = 4;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        READ2 = 3'd3,
        RESP  = 3'd4
    } state_t;

    // True when addr falls in the aligned window of 4<<abits bytes at base.
    function automatic logic win_hit(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned abits);
        return (addr >> (abits + 32'd2)) == (base >> (abits + 32'd2));
    endfunction

endpackage

// File: rtl/ram_bus_bridge.sv
// Adapts the CPU valid/ready memory bus to a single-port registered-read RAM,
// decoding the RAM window and returning one ready pulse per request.
module ram_bus_bridge
    import ram_bus_bridge_pkg::*;
#(
    parameter int unsigned BITS         = 64,
    parameter int unsigned ADDRESS_BITS = 14,
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter logic [31:0] ERR_DATA     = DEF_ERR_DATA
) (
    input  logic                    CLK,
    input  logic                    RSTb,
    input  logic                    mem_valid,
    input  logic [31:0]             mem_addr,
    input  logic [CPU_W-1:0]        mem_wdata,
    input  logic [STRB_W-1:0]       mem_wstrb,
    output logic                    mem_ready,
    output logic [CPU_W-1:0]        mem_rdata,
    output logic                    mem_err,
    output logic [ADDRESS_BITS-1:0] ram_addr,
    output logic [BITS-1:0]         ram_data_in,
    input  logic [BITS-1:0]         ram_data_out,
    output logic                    ram_WRb,
    output logic [STRB_W-1:0]       ram_wstrb
);

    state_t                  state, state_d;
    logic                    ready_d, err_d, wrb_d;
    logic [CPU_W-1:0]        rdata_d;
    logic [ADDRESS_BITS-1:0] addr_d;
    logic [BITS-1:0]         data_in_d;
    logic [STRB_W-1:0]       wstrb_d;
    logic                    hit;

    // Only the low CPU word of the RAM read data is returned upstream.
    logic unused_ram_hi;
    assign unused_ram_hi = ^ram_data_out[BITS-1:CPU_W];

    assign hit = win_hit(mem_addr, BASE_ADDR, ADDRESS_BITS);

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state       <= IDLE;
            mem_ready   <= 1'b0;
            mem_err     <= 1'b0;
            mem_rdata   <= '0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            ram_WRb     <= 1'b1;
            ram_wstrb   <= '0;
        end else begin
            state       <= state_d;
            mem_ready   <= ready_d;
            mem_err     <= err_d;
            mem_rdata   <= rdata_d;
            ram_addr    <= addr_d;
            ram_data_in <= data_in_d;
            ram_WRb     <= wrb_d;
            ram_wstrb   <= wstrb_d;
        end
    end

    // Next-state and next-output decode; request fields are sampled only in IDLE.
    always_comb begin
        state_d   = state;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        rdata_d   = mem_rdata;
        addr_d    = ram_addr;
        data_in_d = ram_data_in;
        wrb_d     = ram_WRb;
        wstrb_d   = ram_wstrb;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    if (hit) begin
                        addr_d = mem_addr[ADDRESS_BITS+1:2];
                        if (mem_wstrb != '0) begin
                            data_in_d = BITS'(mem_wdata);
                            wstrb_d   = mem_wstrb;
                            wrb_d     = 1'b0;
                            state_d   = WRITE;
                        end else begin
                            state_d   = READ;
                        end
                    end else begin
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = (mem_wstrb == '0) ? ERR_DATA : '0;
                        state_d = RESP;
                    end
                end
            end
            WRITE: begin
                wrb_d   = 1'b1;
                wstrb_d = '0;
                ready_d = 1'b1;
                state_d = RESP;
            end
            READ: begin
                state_d = READ2;
            end
            READ2: begin
                rdata_d = ram_data_out[CPU_W-1:0];
                ready_d = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                wrb_d   = 1'b1;
                wstrb_d = '0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Directed bench for ram_bus_bridge with a behavioural single-port RAM model.
module tb_ram_bus_bridge;

    localparam int unsigned BITS = 64;
    localparam int unsigned AW   = 14;

    logic            CLK = 1'b0;
    logic            RSTb;
    logic            mem_valid;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_ready;
    logic [31:0]     mem_rdata;
    logic            mem_err;
    logic [AW-1:0]   ram_addr;
    logic [BITS-1:0] ram_data_in;
    logic [BITS-1:0] ram_data_out;
    logic            ram_WRb;
    logic [3:0]      ram_wstrb;

    int total = 0;
    int bad   = 0;
    int wr_lows = 0;

    logic [BITS-1:0] mem [0:(1<<AW)-1];
    logic [BITS-1:0] wword;

    ram_bus_bridge dut (
        .CLK(CLK), .RSTb(RSTb),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out), .ram_WRb(ram_WRb), .ram_wstrb(ram_wstrb)
    );

    always #5 CLK = ~CLK;

    // RAM model: byte-strobed write on WRb low, registered read every edge.
    always @(posedge CLK) begin
        wword = mem[ram_addr];
        if (!ram_WRb)
            for (int b = 0; b < 4; b++)
                if (ram_wstrb[b]) wword[8*b +: 8] = ram_data_in[8*b +: 8];
        mem[ram_addr] <= wword;
        ram_data_out  <= mem[ram_addr];
    end

    always @(negedge CLK) if (!ram_WRb) wr_lows++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request; returns edges from acceptance to ready, read data and error.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [31:0] rd, output logic er);
        @(negedge CLK);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        lat = 0;
        do begin
            @(posedge CLK); #1; lat++;
        end while (!mem_ready && lat < 10);
        rd = mem_rdata; er = mem_err;
        if (!mem_ready) chk("ready_timeout", 64'(mem_ready), 64'd1);
        mem_valid = 1'b0; mem_addr = 32'hFFFF_FFFC; mem_wdata = '1; mem_wstrb = 4'hF;
        @(posedge CLK); #1;
        chk("ready_drop", 64'(mem_ready), 64'd0);
    endtask

    int          lat, w0, b2b_idx[$];
    logic [31:0] rd, b2b_rd[$];
    logic        er;

    initial begin
        RSTb = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        for (int i = 0; i < (1<<AW); i++) mem[i] = 64'h0;
        mem[5] = 64'h5555_5555;
        mem[0] = 64'h0A0A_0A0A;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_ready", 64'(mem_ready), 64'd0);
        chk("rst_wrb", 64'(ram_WRb), 64'd1);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);
        chk("rst_addr", 64'(ram_addr), 64'd0);
        @(negedge CLK); RSTb = 1'b1;

        // 1: reset mid-write drops the request without touching RAM
        @(negedge CLK);
        mem_valid = 1'b1; mem_addr = 32'h0001_0014; mem_wdata = 32'h9999_9999; mem_wstrb = 4'hF;
        @(posedge CLK); #2;
        chk("t1_wrb_low", 64'(ram_WRb), 64'd0);
        RSTb = 1'b0; #1;
        chk("t1_wrb_rst", 64'(ram_WRb), 64'd1);
        chk("t1_ready_rst", 64'(mem_ready), 64'd0);
        mem_valid = 1'b0;
        @(posedge CLK); #1;
        chk("t1_ram_kept", mem[5], 64'h5555_5555);
        @(negedge CLK); RSTb = 1'b1;

        // 2: full-word write then read back
        w0 = wr_lows;
        do_req(32'h0001_0010, 32'h1234_5678, 4'hF, lat, rd, er);
        chk("t2_wr_lat", 64'(lat), 64'd2);
        chk("t2_wr_err", 64'(er), 64'd0);
        chk("t2_ram_addr", 64'(ram_addr), 64'd4);
        chk("t2_wr_lows", 64'(wr_lows - w0), 64'd1);
        chk("t2_data_in", ram_data_in, 64'h0000_0000_1234_5678);
        chk("t2_wstrb_clr", 64'(ram_wstrb), 64'd0);
        chk("t2_mem", mem[4], 64'h1234_5678);
        w0 = wr_lows;
        do_req(32'h0001_0012, 32'h0, 4'h0, lat, rd, er);
        chk("t2_rd_lat", 64'(lat), 64'd3);
        chk("t2_rd_data", 64'(rd), 64'h1234_5678);
        chk("t2_rd_lows", 64'(wr_lows - w0), 64'd0);
        chk("t2_rdata_hold", 64'(mem_rdata), 64'h1234_5678);

        // 3: partial strobe merges one byte
        do_req(32'h0001_0030, 32'h1111_1111, 4'hF, lat, rd, er);
        do_req(32'h0001_0030, 32'hAABB_CCDD, 4'b0100, lat, rd, er);
        do_req(32'h0001_0030, 32'h0, 4'h0, lat, rd, er);
        chk("t3_merge", 64'(rd), 64'h11BB_1111);

        // 4: read and write misses
        w0 = wr_lows;
        do_req(32'h0002_0000, 32'h0, 4'h0, lat, rd, er);
        chk("t4_rd_lat", 64'(lat), 64'd1);
        chk("t4_rd_err", 64'(er), 64'd1);
        chk("t4_rd_data", 64'(rd), 64'hDEAD_BEEF);
        do_req(32'h0003_0000, 32'h7777_7777, 4'hF, lat, rd, er);
        chk("t4_wr_lat", 64'(lat), 64'd1);
        chk("t4_wr_err", 64'(er), 64'd1);
        chk("t4_wr_data", 64'(rd), 64'd0);
        chk("t4_lows", 64'(wr_lows - w0), 64'd0);
        chk("t4_ram_kept", mem[0], 64'h0A0A_0A0A);
        do_req(32'h0001_0010, 32'h0, 4'h0, lat, rd, er);
        chk("t4_err_clear", 64'(er), 64'd0);

        // 5: back-to-back write/read/write with valid held throughout
        w0 = wr_lows;
        @(negedge CLK);
        mem_valid = 1'b1; mem_addr = 32'h0001_0020; mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'hF;
        for (int e = 1; e <= 12; e++) begin
            @(posedge CLK); #1;
            if (mem_ready) begin
                b2b_idx.push_back(e);
                b2b_rd.push_back(mem_rdata);
                if (b2b_idx.size() == 1) begin
                    mem_addr = 32'h0001_0020; mem_wstrb = 4'h0; mem_wdata = 32'h0;
                end else if (b2b_idx.size() == 2) begin
                    mem_addr = 32'h0001_0024; mem_wstrb = 4'hF; mem_wdata = 32'h0BAD_C0DE;
                end else begin
                    mem_valid = 1'b0; mem_wstrb = 4'h0;
                end
            end
        end
        chk("t5_pulses", 64'(b2b_idx.size()), 64'd3);
        if (b2b_idx.size() == 3) begin
            chk("t5_edge1", 64'(b2b_idx[0]), 64'd2);
            chk("t5_edge2", 64'(b2b_idx[1]), 64'd6);
            chk("t5_edge3", 64'(b2b_idx[2]), 64'd9);
            chk("t5_rdata", 64'(b2b_rd[1]), 64'hCAFE_F00D);
        end
        chk("t5_lows", 64'(wr_lows - w0), 64'd2);
        chk("t5_mem8", mem[8], 64'hCAFE_F00D);
        chk("t5_mem9", mem[9], 64'h0BAD_C0DE);

        // 6: top word of the window and the first address past it
        do_req(32'h0001_FFFC, 32'h7E57_0001, 4'hF, lat, rd, er);
        chk("t6_addr", 64'(ram_addr), 64'd16383);
        chk("t6_err", 64'(er), 64'd0);
        do_req(32'h0001_FFFF, 32'h0, 4'h0, lat, rd, er);
        chk("t6_rd", 64'(rd), 64'h7E57_0001);
        do_req(32'h0002_0000, 32'h0, 4'h0, lat, rd, er);
        chk("t6_miss", 64'(er), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
